// File: rtl/mvu_pkg.sv
// Shared types and sizing helpers for the MVU stream sequencer.
package mvu_pkg;

  typedef enum logic {FILL, REUSE} mvu_ctrl_state_t;

  function automatic int w_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int sf_of(input int mw, input int simd);
    return mw / simd;
  endfunction

  function automatic int nf_of(input int mh, input int pe);
    return mh / pe;
  endfunction

  function automatic int addr_w(input int mw, input int simd,
                                input int mh, input int pe);
    return w_min1(sf_of(mw, simd) * nf_of(mh, pe));
  endfunction

endpackage

// File: rtl/mvu_act_buf.sv
// One-vector activation buffer: sync write, async read, no data reset.
module mvu_act_buf #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int AW    = 2
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mvu_stream_ctrl.sv
// SF/NF fold sequencer for one MVU stream with activation reuse buffer.
// Optional perf counters are enabled by defining MVU_CTRL_PERF_EN.
module mvu_stream_ctrl
  import mvu_pkg::*;
#(
  parameter int SIMD     = 2,
  parameter int TSrcI    = 4,
  parameter int MATRIX_W = 8,
  parameter int PE       = 2,
  parameter int MATRIX_H = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic in_v,
  output logic in_rdy,
  input  logic [TSrcI*SIMD-1:0] in_act,
  input  logic out_rdy,
  output logic [TSrcI*SIMD-1:0] pe_act,
  output logic [addr_w(MATRIX_W, SIMD, MATRIX_H, PE)-1:0] wgt_addr,
  output logic do_mvu_stream,
  output logic sf_clr,
  output logic beat_last,
  output logic busy
`ifdef MVU_CTRL_PERF_EN
  ,
  output logic [31:0] perf_beats,
  output logic [31:0] perf_stall_in,
  output logic [31:0] perf_stall_out
`endif
);

  localparam int SF = sf_of(MATRIX_W, SIMD);
  localparam int NF = nf_of(MATRIX_H, PE);
  localparam int W  = TSrcI * SIMD;
  localparam int AW = addr_w(MATRIX_W, SIMD, MATRIX_H, PE);
  localparam int SW = w_min1(SF);
  localparam int NW = w_min1(NF);

  mvu_ctrl_state_t state_q, state_d;
  logic [SW-1:0] sf_q, sf_d;
  logic [NW-1:0] nf_q, nf_d;
  logic [W-1:0]  buf_rd;
  logic fill, issue, sf_wrap, nf_wrap;

  always_comb begin
    fill    = (state_q == FILL);
    in_rdy  = fill && out_rdy;
    issue   = !reset && out_rdy && (!fill || in_v);
    sf_wrap = (sf_q == SW'(SF - 1));
    nf_wrap = (nf_q == NW'(NF - 1));
    pe_act  = fill ? in_act : buf_rd;
    wgt_addr      = AW'(int'(nf_q) * SF + int'(sf_q));
    do_mvu_stream = issue;
    sf_clr        = issue && (sf_q == '0);
    beat_last     = issue && sf_wrap;
    busy          = !fill || (sf_q != '0);
  end

  always_comb begin
    state_d = state_q;
    sf_d    = sf_q;
    nf_d    = nf_q;
    if (issue) begin
      if (sf_wrap) begin
        sf_d = '0;
        if (nf_wrap) begin
          nf_d    = '0;
          state_d = FILL;
        end else begin
          nf_d    = nf_q + NW'(1);
          state_d = REUSE;
        end
      end else begin
        sf_d = sf_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      sf_q    <= '0;
      nf_q    <= '0;
    end else begin
      state_q <= state_d;
      sf_q    <= sf_d;
      nf_q    <= nf_d;
    end
  end

  // With a single neuron fold nothing is ever replayed, so no storage.
  if (NF > 1) begin : g_buf
    mvu_act_buf #(
      .DEPTH (SF),
      .W     (W),
      .AW    (SW)
    ) u_buf (
      .clock (clock),
      .we    (issue && fill),
      .addr  (sf_q),
      .wdata (in_act),
      .rdata (buf_rd)
    );
  end else begin : g_nobuf
    assign buf_rd = in_act;
  end

`ifdef MVU_CTRL_PERF_EN
  logic [31:0] beats_q, beats_d;
  logic [31:0] st_in_q, st_in_d;
  logic [31:0] st_out_q, st_out_d;

  always_comb begin
    beats_d  = beats_q + 32'(issue);
    st_in_d  = st_in_q + 32'(fill && !in_v && out_rdy);
    st_out_d = st_out_q + 32'(!out_rdy);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beats_q  <= '0;
      st_in_q  <= '0;
      st_out_q <= '0;
    end else begin
      beats_q  <= beats_d;
      st_in_q  <= st_in_d;
      st_out_q <= st_out_d;
    end
  end

  assign perf_beats     = beats_q;
  assign perf_stall_in  = st_in_q;
  assign perf_stall_out = st_out_q;
`endif

endmodule

// File: tb/tb_mvu_stream_ctrl.sv
// Directed bench for mvu_stream_ctrl (SF=4/NF=2 and SF=1/NF=1 instances).
module tb_mvu_stream_ctrl;

  logic clock = 1'b0;
  logic reset;
  logic in_v, out_rdy;
  logic [7:0] in_act;
  logic in_rdy, do_mvu_stream, sf_clr, beat_last, busy;
  logic [7:0] pe_act;
  logic [2:0] wgt_addr;

  logic in_v2;
  logic [7:0] in_act2;
  logic in_rdy2, do2, clr2, last2, busy2;
  logic [7:0] pe_act2;
  logic [0:0] wgt_addr2;

`ifdef MVU_CTRL_PERF_EN
  logic [31:0] perf_beats, perf_stall_in, perf_stall_out;
  logic [31:0] pb2, psi2, pso2;
`endif

  always #5 clock = ~clock;

  mvu_stream_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .in_v          (in_v),
    .in_rdy        (in_rdy),
    .in_act        (in_act),
    .out_rdy       (out_rdy),
    .pe_act        (pe_act),
    .wgt_addr      (wgt_addr),
    .do_mvu_stream (do_mvu_stream),
    .sf_clr        (sf_clr),
    .beat_last     (beat_last),
    .busy          (busy)
`ifdef MVU_CTRL_PERF_EN
    ,
    .perf_beats     (perf_beats),
    .perf_stall_in  (perf_stall_in),
    .perf_stall_out (perf_stall_out)
`endif
  );

  mvu_stream_ctrl #(
    .MATRIX_W (2),
    .MATRIX_H (2)
  ) dut1 (
    .clock         (clock),
    .reset         (reset),
    .in_v          (in_v2),
    .in_rdy        (in_rdy2),
    .in_act        (in_act2),
    .out_rdy       (out_rdy),
    .pe_act        (pe_act2),
    .wgt_addr      (wgt_addr2),
    .do_mvu_stream (do2),
    .sf_clr        (clr2),
    .beat_last     (last2),
    .busy          (busy2)
`ifdef MVU_CTRL_PERF_EN
    ,
    .perf_beats     (pb2),
    .perf_stall_in  (psi2),
    .perf_stall_out (pso2)
`endif
  );

  typedef struct {
    logic       v;
    logic       r;
    logic [7:0] act;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];
  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  task automatic add(input logic v, input logic r, input logic [7:0] act,
                     input logic d, input logic c, input logic l,
                     input logic [2:0] a, input logic [7:0] pe,
                     input logic rdy, input logic bz);
    vec_t t;
    t.v   = v;
    t.r   = r;
    t.act = act;
    t.exp = {d, c, l, a, pe, rdy, bz};
    vecs.push_back(t);
  endtask

  function automatic logic [15:0] obs();
    return {do_mvu_stream, sf_clr, beat_last, wgt_addr,
            pe_act, in_rdy, busy};
  endfunction

  localparam logic [7:0] A0 = 8'h10, A1 = 8'h32, A2 = 8'h54, A3 = 8'h76;
  localparam logic [7:0] B0 = 8'h98, B1 = 8'hBA, B2 = 8'hDC, B3 = 8'hFE;
  localparam logic [7:0] C0 = 8'h01, C1 = 8'h23, C2 = 8'h45, C3 = 8'h67;

  initial begin
    int e_beats, e_sin, e_sout;
    reset   = 1'b1;
    in_v    = 1'b1;
    out_rdy = 1'b1;
    in_act  = A0;
    in_v2   = 1'b0;
    in_act2 = 8'h00;

    // reset row first, then vectors A (scn 1), B (scn 4/2), C (scn 3)
    add(0,1,8'h00, 0,0,0,0,8'h00,1,0);
    add(1,1,A0, 1,1,0,0,A0,1,0);
    add(1,1,A1, 1,0,0,1,A1,1,1);
    add(1,1,A2, 1,0,0,2,A2,1,1);
    add(1,1,A3, 1,0,1,3,A3,1,1);
    add(1,1,B0, 1,1,0,4,A0,0,1);
    add(1,1,B0, 1,0,0,5,A1,0,1);
    add(1,1,B0, 1,0,0,6,A2,0,1);
    add(1,1,B0, 1,0,1,7,A3,0,1);
    add(1,1,B0, 1,1,0,0,B0,1,0);
    add(1,1,B1, 1,0,0,1,B1,1,1);
    add(1,0,B2, 0,0,0,2,B2,0,1);
    add(1,0,B2, 0,0,0,2,B2,0,1);
    add(1,0,B2, 0,0,0,2,B2,0,1);
    add(1,1,B2, 1,0,0,2,B2,1,1);
    add(1,1,B3, 1,0,1,3,B3,1,1);
    add(0,1,8'h00, 1,1,0,4,B0,0,1);
    add(0,0,8'h00, 0,0,0,5,B1,0,1);
    add(0,1,8'h00, 1,0,0,5,B1,0,1);
    add(0,1,8'h00, 1,0,0,6,B2,0,1);
    add(0,1,8'h00, 1,0,1,7,B3,0,1);
    add(0,1,8'h00, 0,0,0,0,8'h00,1,0);
    add(1,1,C0, 1,1,0,0,C0,1,0);
    add(0,1,8'h00, 0,0,0,1,8'h00,1,1);
    add(1,1,C1, 1,0,0,1,C1,1,1);
    add(1,1,C2, 1,0,0,2,C2,1,1);
    add(0,1,8'h00, 0,0,0,3,8'h00,1,1);
    add(1,1,C3, 1,0,1,3,C3,1,1);
    add(0,1,8'h00, 1,1,0,4,C0,0,1);

    #2;
    chk("rst_outputs", {28'd0, do_mvu_stream, sf_clr, beat_last, busy}, 0);
    chk("rst_addr", {29'd0, wgt_addr}, 0);
    chk("rst_rdy_hi", {31'd0, in_rdy}, 1);
    out_rdy = 1'b0;
    #1;
    chk("rst_rdy_lo", {31'd0, in_rdy}, 0);
    in_v    = 1'b0;
    out_rdy = 1'b1;
    in_act  = 8'h00;
    @(posedge clock);
    #1;
    reset = 1'b0;

    e_beats = 0;
    e_sin   = 0;
    e_sout  = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      in_v    = vecs[i].v;
      out_rdy = vecs[i].r;
      in_act  = vecs[i].act;
      e_beats += int'(vecs[i].exp[15]);
      e_sout  += int'(!vecs[i].r);
      e_sin   += int'(vecs[i].exp[1] && !vecs[i].v);
      @(negedge clock);
      chk($sformatf("row%0d", i), {16'd0, obs()}, {16'd0, vecs[i].exp});
      @(posedge clock);
      #1;
    end

`ifdef MVU_CTRL_PERF_EN
    chk("perf_beats", perf_beats, e_beats);
    chk("perf_stall_in", perf_stall_in, e_sin);
    chk("perf_stall_out", perf_stall_out, e_sout);
`endif

    // reset while REUSE is about to issue addr 5
    in_v    = 1'b0;
    out_rdy = 1'b1;
    @(negedge clock);
    chk("reuse_addr5", {24'd0, do_mvu_stream, wgt_addr, pe_act[3:0]},
        {24'd0, 1'b1, 3'd5, C1[3:0]});
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_busy_rdy", {29'd0, busy, in_rdy, do_mvu_stream}, 3'b010);
`ifdef MVU_CTRL_PERF_EN
    chk("midrst_perf", perf_beats | perf_stall_out, 0);
`endif
    @(posedge clock);
    #1;
    reset  = 1'b0;
    in_v   = 1'b1;
    in_act = 8'hA5;
    @(negedge clock);
    chk("post_rst_beat", {16'd0, obs()},
        {16'd0, 1'b1, 1'b1, 1'b0, 3'd0, 8'hA5, 1'b1, 1'b0});
    @(posedge clock);
    #1;
    in_v = 1'b0;

    // SF=1, NF=1 instance
    for (int i = 0; i < 5; i++) begin
      in_v2   = (i != 2);
      in_act2 = 8'(8'h11 * (i + 1));
      @(negedge clock);
      chk($sformatf("sf1_%0d", i),
          {17'd0, do2, clr2, last2, wgt_addr2, pe_act2, in_rdy2, busy2},
          {17'd0, {3{in_v2}}, 1'b0, in_act2, 1'b1, 1'b0});
      @(posedge clock);
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
